// File: rtl/adc_dac_ctrl_pkg.sv
// Shared encodings and constants for the ADC-to-DAC sample path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adc_dac_pkg;

   // DAC output source selection.
   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_DELAY = 2'd1,
      MODE_RAMP  = 2'd2,
      MODE_CONST = 2'd3
   } mode_e;

   // PLL-lock cycles required before the sample path is released.
   localparam int unsigned LOCK_WAIT_DEF = 255;

   // Mid-scale code for an offset-binary sample of width w (DAC "silence").
   function automatic logic [31:0] mid_code(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/adc_dac_ctrl_if.sv
// Sample-path bundle between the PLL/ADC/DAC pins and the controller.
// Latency: n/a (wires only).
// Backpressure: none; every signal is valid every sample-clock cycle.
// master: board side (drives lock, mode, controls, ADC sample; reads DAC side)
// slave : controller side (the reverse)
interface adc_dac_ctrl_if #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned OVR_CNT_W = 16
);
   logic                 pll_lock;
   logic [1:0]           mode;
   logic [DATA_W-1:0]    ramp_step;
   logic [DATA_W-1:0]    const_val;
   logic                 ovr_clr;
   logic [DATA_W-1:0]    ad_data;
   logic [DATA_W-1:0]    da_data;
   logic                 sys_ready;
   logic                 ovr_flag;
   logic [OVR_CNT_W-1:0] ovr_cnt;

   modport master (
      output pll_lock, mode, ramp_step, const_val, ovr_clr, ad_data,
      input  da_data, sys_ready, ovr_flag, ovr_cnt
   );

   modport slave (
      input  pll_lock, mode, ramp_step, const_val, ovr_clr, ad_data,
      output da_data, sys_ready, ovr_flag, ovr_cnt
   );
endinterface

// File: rtl/adc_dac_ctrl_delay.sv
// Fixed-depth circular sample delay with fill tracking.
// Latency: rd_dat_o is the sample written DEPTH writes ago (valid once DEPTH writes seen).
// Backpressure: none; one write per enabled cycle, read is combinational.
// Ports: clk, rst (async, active-high), wr_en_i / wr_dat_i write side,
//        flush_i clears fill, rd_dat_o / rd_vld_o oldest sample and its validity.
module sample_delay_line #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wr_dat_i,
   output logic [DATA_W-1:0] rd_dat_o,
   output logic              rd_vld_o
);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;

   // The slot about to be overwritten holds the oldest sample, so it is read
   // in the same cycle it is replaced.
   assign rd_dat_o = mem_q[wr_ptr_q];
   assign rd_vld_o = (fill_q == FILL_W'(DEPTH));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (wr_en_i) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + 1'b1;
      end
      if (flush_i) fill_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Storage carries no reset; stale contents are masked by rd_vld_o.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_dat_i;
   end

endmodule

// File: rtl/adc_dac_ctrl.sv
// Lock-qualified ADC-to-DAC controller: pass / delay / ramp / const output, over-range stats.
// Latency: ad_data->da_data 2 cycles (pass), DELAY_DEPTH+2 (delay); sys_ready LOCK_WAIT+3 after lock.
// Backpressure: none; fixed-rate sample stream, one sample per clk.
// Ports: clk (sample clock), rst (async, active-high), bus (adc_dac_ctrl_if.slave):
//        pll_lock, mode, ramp_step, const_val, ovr_clr, ad_data in; da_data, sys_ready,
//        ovr_flag, ovr_cnt out.
module adc_dac_ctrl
   import adc_dac_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned LOCK_WAIT   = LOCK_WAIT_DEF,
   parameter int unsigned DELAY_DEPTH = 16,
   parameter int unsigned OVR_CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   adc_dac_ctrl_if.slave      bus
);
   localparam logic [DATA_W-1:0] MID = DATA_W'(mid_code(DATA_W));
   localparam int unsigned LCNT_W = $clog2(LOCK_WAIT + 1);
   localparam logic [LCNT_W-1:0] LOCK_DONE = LCNT_W'(LOCK_WAIT);

   // pll_lock comes from the PLL's analog lock detector, hence the synchroniser.
   logic                 lock_meta_q, lock_s_q;
   logic [LCNT_W-1:0]    lock_cnt_q, lock_cnt_d;
   logic                 sys_ready_q, sys_ready_d;
   logic [DATA_W-1:0]    ad_q;
   logic [DATA_W-1:0]    acc_q, acc_d;
   logic [DATA_W-1:0]    da_q, da_d;
   logic                 ovr_flag_q, ovr_flag_d;
   logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
   logic                 ovr_evt;
   logic [DATA_W-1:0]    dly_dat;
   logic                 dly_vld;
   mode_e                mode;

   assign mode = mode_e'(bus.mode);

   // Delay line runs in every mode so switching into delay mode yields
   // real history immediately once it has filled.
   sample_delay_line #(
      .DATA_W (DATA_W),
      .DEPTH  (DELAY_DEPTH)
   ) u_dly (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (sys_ready_q),
      .flush_i  (!sys_ready_q),
      .wr_dat_i (ad_q),
      .rd_dat_o (dly_dat),
      .rd_vld_o (dly_vld)
   );

   // Rails are treated as clipping; only counted once the path is live.
   assign ovr_evt = sys_ready_q && ((ad_q == '1) || (ad_q == '0));

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (!lock_s_q)                   lock_cnt_d = '0;
      else if (lock_cnt_q != LOCK_DONE) lock_cnt_d = lock_cnt_q + 1'b1;

      sys_ready_d = (lock_cnt_q == LOCK_DONE) && lock_s_q;

      // Accumulator parks at zero outside ramp mode so every ramp starts at 0.
      acc_d = (mode == MODE_RAMP) ? acc_q + bus.ramp_step : '0;

      da_d = MID;
      if (sys_ready_q) begin
         case (mode)
            MODE_PASS:  da_d = ad_q;
            MODE_DELAY: da_d = dly_vld ? dly_dat : MID;
            MODE_RAMP:  da_d = acc_q;
            MODE_CONST: da_d = bus.const_val;
         endcase
      end

      // A coincident event beats the clear so no clipping goes unreported.
      ovr_flag_d = ovr_flag_q;
      if (bus.ovr_clr) ovr_flag_d = 1'b0;
      if (ovr_evt)     ovr_flag_d = 1'b1;

      ovr_cnt_d = ovr_cnt_q;
      if (ovr_evt && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         lock_cnt_q  <= '0;
         sys_ready_q <= 1'b0;
         ad_q        <= '0;
         acc_q       <= '0;
         da_q        <= MID;
         ovr_flag_q  <= 1'b0;
         ovr_cnt_q   <= '0;
      end else begin
         lock_meta_q <= bus.pll_lock;
         lock_s_q    <= lock_meta_q;
         lock_cnt_q  <= lock_cnt_d;
         sys_ready_q <= sys_ready_d;
         ad_q        <= bus.ad_data;
         acc_q       <= acc_d;
         da_q        <= da_d;
         ovr_flag_q  <= ovr_flag_d;
         ovr_cnt_q   <= ovr_cnt_d;
      end
   end

   assign bus.da_data   = da_q;
   assign bus.sys_ready = sys_ready_q;
   assign bus.ovr_flag  = ovr_flag_q;
   assign bus.ovr_cnt   = ovr_cnt_q;

endmodule

// File: tb/tb_adc_dac_ctrl.sv
// Directed bench for adc_dac_ctrl with a due-cycle scoreboard of expected outputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_dac_ctrl;
   import adc_dac_pkg::*;

   localparam int LW  = 255;
   localparam int DD  = 16;
   localparam logic [15:0] MIDV = 16'h0080;

   localparam int SEL_DA   = 0;
   localparam int SEL_RDY  = 1;
   localparam int SEL_FLAG = 2;
   localparam int SEL_CNT  = 3;

   typedef struct {
      int          due;
      int          sel;
      logic [15:0] exp;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   adc_dac_ctrl_if #(.DATA_W(8), .OVR_CNT_W(16)) bus ();

   adc_dac_ctrl #(
      .DATA_W      (8),
      .LOCK_WAIT   (LW),
      .DELAY_DEPTH (DD),
      .OVR_CNT_W   (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         SEL_DA:   return {8'h00, bus.da_data};
         SEL_RDY:  return {15'h0, bus.sys_ready};
         SEL_FLAG: return {15'h0, bus.ovr_flag};
         default:  return bus.ovr_cnt;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push(input int due, input int sel, input logic [15:0] exp, input string tag);
      exp_t e;
      e.due = due; e.sel = sel; e.exp = exp; e.tag = tag;
      sb.push_back(e);
   endtask

   // Advance one clock, then compare every expectation due at this edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            chk(sb[i].tag, observe(sb[i].sel), sb[i].exp);
            sb.delete(i);
         end
      end
   endtask

   initial begin
      int c0, k, a, r2;

      rst = 1'b1;
      bus.pll_lock  = 1'b0;
      bus.mode      = MODE_PASS;
      bus.ramp_step = 8'h00;
      bus.const_val = 8'h00;
      bus.ovr_clr   = 1'b0;
      bus.ad_data   = 8'h55;
      #1;
      chk("rst_da",   observe(SEL_DA),   MIDV);
      chk("rst_rdy",  observe(SEL_RDY),  16'h0);
      chk("rst_flag", observe(SEL_FLAG), 16'h0);
      chk("rst_cnt",  observe(SEL_CNT),  16'h0);

      repeat (3) tick();
      rst = 1'b0;
      bus.mode      = MODE_CONST;
      bus.const_val = 8'h33;
      tick();

      // Lock sequence: ready exactly LW+3 edges after pll_lock rises.
      c0 = cyc;
      bus.pll_lock = 1'b1;
      push(c0 + 10,     SEL_RDY, 16'h0,  "rdy_early");
      push(c0 + 10,     SEL_DA,  MIDV,   "da_mid_early");
      push(c0 + LW + 2, SEL_RDY, 16'h0,  "rdy_pre");
      push(c0 + LW + 2, SEL_DA,  MIDV,   "da_mid_pre");
      push(c0 + LW + 3, SEL_RDY, 16'h1,  "rdy_rise");
      push(c0 + LW + 3, SEL_DA,  MIDV,   "da_mid_at_rise");
      push(c0 + LW + 4, SEL_DA,  16'h33, "da_const_live");
      while (cyc < c0 + LW + 4) tick();

      // Passthrough: two-cycle latency.
      k = cyc;
      bus.mode = MODE_PASS;
      push(k + 1, SEL_DA, 16'h55, "pass_old_adq");
      bus.ad_data = 8'h10; push(cyc + 2, SEL_DA, 16'h10, "pass_10"); tick();
      bus.ad_data = 8'h20; push(cyc + 2, SEL_DA, 16'h20, "pass_20"); tick();
      bus.ad_data = 8'h30; push(cyc + 2, SEL_DA, 16'h30, "pass_30"); tick();
      bus.ad_data = 8'h40; tick(); tick();

      // One-cycle lock drop: ready falls within 3 cycles, full recount follows.
      a = cyc;
      bus.pll_lock = 1'b0;
      push(a + 2,      SEL_RDY, 16'h1, "rdy_hold_sync");
      push(a + 3,      SEL_RDY, 16'h0, "rdy_drop");
      push(a + 4,      SEL_DA,  MIDV,  "da_mid_lockloss");
      push(a + 3 + LW, SEL_RDY, 16'h0, "rdy_recount");
      push(a + 4 + LW, SEL_RDY, 16'h1, "rdy_relock");
      tick();
      bus.pll_lock = 1'b1;
      bus.mode     = MODE_DELAY;
      r2 = a + 4 + LW;
      while (cyc < r2 - 1) tick();

      // Delay mode after fresh ready: MID until DD samples stored, then latency DD+2.
      for (int j = 0; j <= DD; j++) push(r2 + j, SEL_DA, MIDV, "dly_fill_mid");
      for (int j = 0; j < 24; j++) begin
         bus.ad_data = 8'(j + 1);
         push(cyc + DD + 2, SEL_DA, 16'(j + 1), "dly_data");
         tick();
      end
      bus.ad_data = 8'h40;
      repeat (DD + 4) tick();

      // Ramp with silent wrap, then const, then ramp restarts at zero.
      k = cyc;
      bus.mode      = MODE_RAMP;
      bus.ramp_step = 8'h40;
      push(k + 1, SEL_DA, 16'h00, "ramp_0");
      push(k + 2, SEL_DA, 16'h40, "ramp_1");
      push(k + 3, SEL_DA, 16'h80, "ramp_2");
      push(k + 4, SEL_DA, 16'hC0, "ramp_3");
      push(k + 5, SEL_DA, 16'h00, "ramp_wrap");
      repeat (5) tick();
      bus.mode      = MODE_CONST;
      bus.const_val = 8'h5A;
      push(cyc + 1, SEL_DA, 16'h5A, "const_5a");
      tick();
      bus.mode = MODE_RAMP;
      push(cyc + 1, SEL_DA, 16'h00, "ramp_restart");
      push(cyc + 2, SEL_DA, 16'h40, "ramp_restart_1");
      tick(); tick();

      // Over-range: three 0xFF, one 0x00 with coincident clear.
      bus.mode = MODE_PASS;
      k = cyc;
      push(k + 2, SEL_FLAG, 16'h1,  "ovr_set");
      push(k + 2, SEL_CNT,  16'h1,  "ovr_cnt1");
      push(k + 2, SEL_DA,   16'hFF, "pass_ff");
      push(k + 4, SEL_CNT,  16'h3,  "ovr_cnt3");
      push(k + 4, SEL_FLAG, 16'h1,  "evt_beats_clr");
      push(k + 5, SEL_CNT,  16'h4,  "ovr_cnt4");
      push(k + 5, SEL_FLAG, 16'h1,  "ovr_flag_zero_evt");
      push(k + 5, SEL_DA,   16'h00, "pass_00");
      push(k + 6, SEL_FLAG, 16'h1,  "ovr_flag_stays");
      push(k + 6, SEL_CNT,  16'h4,  "ovr_cnt_hold");
      bus.ad_data = 8'hFF; tick();
      bus.ad_data = 8'hFF; tick();
      bus.ad_data = 8'hFF; tick();
      bus.ad_data = 8'h00; bus.ovr_clr = 1'b1; tick();
      bus.ad_data = 8'h40; bus.ovr_clr = 1'b0;
      tick(); tick(); tick();
      bus.ovr_clr = 1'b1;
      push(cyc + 1, SEL_FLAG, 16'h0, "lone_clr_flag");
      push(cyc + 1, SEL_CNT,  16'h4, "lone_clr_cnt");
      tick();
      bus.ovr_clr = 1'b0;
      tick();

      // Asynchronous reset mid-cycle, then a slow re-arm through the synchroniser.
      #2 rst = 1'b1;
      #1;
      chk("arst_da",  observe(SEL_DA),  MIDV);
      chk("arst_rdy", observe(SEL_RDY), 16'h0);
      chk("arst_cnt", observe(SEL_CNT), 16'h0);
      tick();
      rst = 1'b0;
      push(cyc + 5, SEL_RDY, 16'h0, "rdy_after_arst");
      push(cyc + 5, SEL_DA,  MIDV,  "da_after_arst");
      repeat (6) tick();

      chk("sb_drained", 16'(sb.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
